sme_feeder: RTL and testbench
=============================

# sme_feeder

Front-end stage that sits directly upstream of the string-matching engine (SME). It accepts a ready/valid byte stream of tagged string and pattern records, buffers each record completely, then replays it to the SME as one gap-free `isstring`/`ispattern` burst. After each pattern burst it waits for the SME verdict and returns it as a single-cycle result with a timeout guard. This keeps upstream stalls from ever appearing inside an SME burst.

## Interface
Parameters:
- `STR_MAX`, default 32: maximum string length in characters.
- `PAT_MAX`, default 8: maximum pattern length in characters.
- `TIMEOUT`, default 64: number of cycles in WAIT_RES before a timeout result is forced.

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: asynchronous, active-high.
- `in_valid`, in, 1: upstream byte valid.
- `in_ready`, out, 1: feeder can accept a byte.
- `in_data`, in, 8: character.
- `in_kind`, in, 1: 0 = string record, 1 = pattern record. Sampled on the first byte of a record only.
- `in_last`, in, 1: this byte ends the record.
- `chardata`, out, 8: character to the SME.
- `isstring`, out, 1: string burst strobe to the SME.
- `ispattern`, out, 1: pattern burst strobe to the SME.
- `sme_valid`, in, 1: SME result valid.
- `sme_match`, in, 1: SME match flag.
- `sme_index`, in, 5: SME match index.
- `res_valid`, out, 1: one-cycle result pulse.
- `res_match`, out, 1: result match flag.
- `res_index`, out, 5: result match index.
- `res_timeout`, out, 1: result came from timeout, not from the SME.
- `err`, out, 1: one-cycle pulse on overflow or on an orphan pattern.

## Operation
- A byte transfers when `in_valid && in_ready`.
- FSM states: IDLE, COLLECT, EMIT, WAIT_RES.
- IDLE: `in_ready`=1. The first accepted byte latches `kind`, is written to buffer slot 0, and sets `wr_cnt`=1.
  - If that byte also has `in_last`, go to EMIT.
  - Otherwise go to COLLECT.
- COLLECT: `in_ready`=1.
  - Each accepted byte is written at `wr_cnt`, and `wr_cnt` increments.
  - Once `wr_cnt` has reached the limit (`STR_MAX` for strings, `PAT_MAX` for patterns), further bytes are accepted but discarded. `err` pulses once per record, on the first discarded byte.
  - The byte with `in_last` moves the FSM to EMIT.
  - The discard rule also applies to the IDLE first byte (its limit is ≥1, so the first byte is always stored).
- Orphan pattern: a pattern record arriving while `str_loaded`=0 is fully consumed, nothing is emitted, and `err` pulses on its last byte. The FSM returns to IDLE.
- EMIT: `in_ready`=0.
  - Drives `chardata`=buf[`rd_cnt`] with `isstring`=~kind and `ispattern`=kind for exactly `wr_cnt` consecutive cycles, `rd_cnt` running 0..`wr_cnt`-1.
  - After the final character:
    - string: set `str_loaded`, go to IDLE.
    - pattern: go to WAIT_RES with the timer cleared.
- WAIT_RES: `in_ready`=0; the timer increments each cycle.
  - `sme_valid`=1: register `sme_match`/`sme_index` into `res_match`/`res_index`, `res_timeout`=0, pulse `res_valid`, go to IDLE.
  - Timer reaches `TIMEOUT`-1 with no `sme_valid`: pulse `res_valid` with `res_match`=0, `res_index`=0, `res_timeout`=1, go to IDLE.
  - If `sme_valid` arrives on the timeout cycle, the SME result wins.
- `sme_valid` outside WAIT_RES is ignored.
- `str_loaded` persists across patterns. A new string record replaces it (the buffer is overwritten, and the new length is whatever `wr_cnt` reaches).
- Reset values: all outputs 0, `in_ready`=0 during reset, `str_loaded`=0, FSM=IDLE, counters 0, buffer contents don't-care.
- Reset mid-EMIT: `isstring`/`ispattern` drop within the same reset assertion, and no partial burst resumes afterwards.

## Timing
- All outputs are registered. `in_ready` is decoded from the registered state.
- The first burst character appears on the cycle after the `in_last` byte is accepted. A burst of N characters occupies exactly N consecutive cycles with no gaps.
- `res_valid` is asserted on the cycle after `sme_valid` is sampled.
- `in_ready` returns to 1 on the cycle after the last burst character (string) or after the `res_valid` pulse (pattern).
- Counter widths:
  - `wr_cnt` and `rd_cnt`: $clog2(`STR_MAX`+1).
  - timer: $clog2(`TIMEOUT`).
- No wrap-around: `wr_cnt` saturates at the limit.
- `err` and `res_valid` can never be asserted in the same cycle, because they are generated in mutually exclusive states.

## Structure
- Package `sme_pkg`:
  - state enum `sme_feed_state_t`;
  - constants `SME_STR_MAX`=32, `SME_PAT_MAX`=8;
  - character constants `CH_SPACE`=8'h20, `CH_DOT`=8'h2E, `CH_CARET`=8'h5E, `CH_DOLLAR`=8'h24, shared with the SME and its bench.
- Sub-module `sme_char_buf`:
  - `STR_MAX`×8 register array;
  - synchronous write port (`we`, `waddr`, `wdata`);
  - combinational read port (`raddr`, `rdata`).
- The FSM, counters, timer and result registers live in `sme_feeder`.

## Test plan
- String "abcd" (kind 0, `in_last` on 'd') → starting the cycle after 'd' is accepted, `isstring`=1 for 4 consecutive cycles with `chardata` 61,62,63,64; `in_ready`=0 throughout; no `res_valid`.
- After that string, pattern "bc" → `ispattern`=1 for 2 cycles (62,63). The SME model then returns `sme_valid`=1, `sme_match`=1, `sme_index`=1 five cycles later → `res_valid`=1 one cycle later with `res_match`=1, `res_index`=1, `res_timeout`=0.
- Pattern "x" immediately after reset → `err`=1 on the 'x' accept cycle; `ispattern` never asserts; `in_ready`=1 on the next cycle.
- 10-byte pattern "abcdefghij" after a string → `err` pulses once, on the 'i' accept cycle; burst emits exactly "abcdefgh" (8 cycles).
- Pattern with a silent SME → `res_valid` with `res_timeout`=1, `res_match`=0, `res_index`=0 exactly 64 cycles after WAIT_RES entry.
- Assert `reset` on the 2nd cycle of a 4-character string burst → `isstring`=0 while reset is high; after release `str_loaded`=0, so a following pattern produces `err` and no burst.

Source files
------------

// File: rtl/sme_feeder_pkg.sv
// Shared types and constants for the SME front-end feeder and the SME itself.
package sme_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_COLLECT  = 2'd1,
    ST_EMIT     = 2'd2,
    ST_WAIT_RES = 2'd3
  } sme_feed_state_t;

  localparam int SME_STR_MAX = 32;
  localparam int SME_PAT_MAX = 8;

  localparam logic [7:0] CH_SPACE  = 8'h20;
  localparam logic [7:0] CH_DOT    = 8'h2E;
  localparam logic [7:0] CH_CARET  = 8'h5E;
  localparam logic [7:0] CH_DOLLAR = 8'h24;

endpackage

// File: rtl/sme_feeder_if.sv
// Upstream byte stream, SME burst/verdict lines and result/error outputs of the feeder.
// Handshake: a byte transfers on a rising clk edge where in_valid && in_ready; in_valid,
// in_data, in_kind and in_last must hold until that edge; in_ready never depends on in_valid.
interface sme_feeder_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_kind;
  logic       in_last;
  logic [7:0] chardata;
  logic       isstring;
  logic       ispattern;
  logic       sme_valid;
  logic       sme_match;
  logic [4:0] sme_index;
  logic       res_valid;
  logic       res_match;
  logic [4:0] res_index;
  logic       res_timeout;
  logic       err;

  modport slave (
    input  in_valid, in_data, in_kind, in_last, sme_valid, sme_match, sme_index,
    output in_ready, chardata, isstring, ispattern,
           res_valid, res_match, res_index, res_timeout, err
  );

  modport master (
    output in_valid, in_data, in_kind, in_last, sme_valid, sme_match, sme_index,
    input  in_ready, chardata, isstring, ispattern,
           res_valid, res_match, res_index, res_timeout, err
  );
endinterface

// File: rtl/sme_feeder_char_buf.sv
// Record buffer: register array with a synchronous write port and a combinational read port.
module sme_char_buf #(
  parameter int STR_MAX = 32,
  localparam int AW = $clog2(STR_MAX)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [STR_MAX];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sme_feeder.sv
// Buffers one tagged string/pattern record, replays it to the SME as a gap-free burst,
// then returns the SME verdict (or a timeout) as a single-cycle result.
module sme_feeder
  import sme_pkg::*;
#(
  parameter int STR_MAX = SME_STR_MAX,
  parameter int PAT_MAX = SME_PAT_MAX,
  parameter int TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            reset,
  sme_feeder_if.slave     bus,
  output sme_feed_state_t dbg_state
);

  localparam int CW = $clog2(STR_MAX + 1);
  localparam int TW = $clog2(TIMEOUT);
  localparam int AW = $clog2(STR_MAX);

  sme_feed_state_t state, state_d;
  logic          kind, kind_d, str_loaded, str_loaded_d, ovf, ovf_d, ready_q, ready_d;
  logic [CW-1:0] wr_cnt, wr_cnt_d, rd_cnt, rd_cnt_d;
  logic [TW-1:0] timer, timer_d;
  logic [7:0]    chardata_q, chardata_d;
  logic          isstring_q, isstring_d, ispattern_q, ispattern_d;
  logic          res_valid_q, res_valid_d, res_match_q, res_match_d;
  logic [4:0]    res_index_q, res_index_d;
  logic          res_timeout_q, res_timeout_d, err_q, err_d;

  logic          accept, cur_kind, room, ovf_cur, buf_we;
  logic [CW-1:0] limit, cnt_base;
  logic [AW-1:0] buf_waddr, buf_raddr;
  logic [7:0]    buf_rdata;

  sme_char_buf #(.STR_MAX(STR_MAX)) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (buf_waddr),
    .wdata (bus.in_data),
    .raddr (buf_raddr),
    .rdata (buf_rdata)
  );

  // In IDLE the first byte of a new record is judged on its own tag and an empty count.
  assign accept    = bus.in_valid && ready_q;
  assign cur_kind  = (state == ST_IDLE) ? bus.in_kind : kind;
  assign limit     = cur_kind ? CW'(PAT_MAX) : CW'(STR_MAX);
  assign cnt_base  = (state == ST_IDLE) ? '0 : wr_cnt;
  assign ovf_cur   = (state == ST_IDLE) ? 1'b0 : ovf;
  assign room      = cnt_base < limit;
  assign buf_we    = accept && room;
  assign buf_waddr = cnt_base[AW-1:0];
  // During EMIT the read port looks one character ahead of the registered output.
  assign buf_raddr = (state == ST_EMIT) ? AW'(rd_cnt + CW'(1)) : '0;

  always_comb begin
    state_d       = state;
    kind_d        = kind;
    str_loaded_d  = str_loaded;
    ovf_d         = ovf;
    wr_cnt_d      = wr_cnt;
    rd_cnt_d      = rd_cnt;
    timer_d       = timer;
    chardata_d    = '0;
    isstring_d    = 1'b0;
    ispattern_d   = 1'b0;
    res_valid_d   = 1'b0;
    res_match_d   = res_match_q;
    res_index_d   = res_index_q;
    res_timeout_d = res_timeout_q;
    err_d         = 1'b0;

    case (state)
      ST_IDLE, ST_COLLECT: begin
        if (accept) begin
          kind_d = cur_kind;
          ovf_d  = ovf_cur;
          if (room) begin
            wr_cnt_d = cnt_base + CW'(1);
          end else begin
            wr_cnt_d = cnt_base;
            if (!ovf_cur) begin
              err_d = 1'b1;
              ovf_d = 1'b1;
            end
          end
          if (bus.in_last) begin
            if (cur_kind && !str_loaded) begin
              err_d   = 1'b1;
              state_d = ST_IDLE;
            end else begin
              state_d     = ST_EMIT;
              rd_cnt_d    = '0;
              // A one-byte record is still being written, so bypass the buffer.
              chardata_d  = (state == ST_IDLE) ? bus.in_data : buf_rdata;
              isstring_d  = !cur_kind;
              ispattern_d = cur_kind;
            end
          end else begin
            state_d = ST_COLLECT;
          end
        end
      end
      ST_EMIT: begin
        if (rd_cnt == wr_cnt - CW'(1)) begin
          if (!kind) begin
            str_loaded_d = 1'b1;
            state_d      = ST_IDLE;
          end else begin
            timer_d = '0;
            state_d = ST_WAIT_RES;
          end
        end else begin
          rd_cnt_d    = rd_cnt + CW'(1);
          chardata_d  = buf_rdata;
          isstring_d  = !kind;
          ispattern_d = kind;
        end
      end
      ST_WAIT_RES: begin
        timer_d = timer + TW'(1);
        if (bus.sme_valid) begin
          res_valid_d   = 1'b1;
          res_match_d   = bus.sme_match;
          res_index_d   = bus.sme_index;
          res_timeout_d = 1'b0;
          state_d       = ST_IDLE;
        end else if (timer == TW'(TIMEOUT - 1)) begin
          res_valid_d   = 1'b1;
          res_match_d   = 1'b0;
          res_index_d   = '0;
          res_timeout_d = 1'b1;
          state_d       = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Ready reopens only after the result pulse has been presented.
    ready_d = ((state_d == ST_IDLE) || (state_d == ST_COLLECT)) && !res_valid_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      kind          <= 1'b0;
      str_loaded    <= 1'b0;
      ovf           <= 1'b0;
      ready_q       <= 1'b0;
      wr_cnt        <= '0;
      rd_cnt        <= '0;
      timer         <= '0;
      chardata_q    <= '0;
      isstring_q    <= 1'b0;
      ispattern_q   <= 1'b0;
      res_valid_q   <= 1'b0;
      res_match_q   <= 1'b0;
      res_index_q   <= '0;
      res_timeout_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state         <= state_d;
      kind          <= kind_d;
      str_loaded    <= str_loaded_d;
      ovf           <= ovf_d;
      ready_q       <= ready_d;
      wr_cnt        <= wr_cnt_d;
      rd_cnt        <= rd_cnt_d;
      timer         <= timer_d;
      chardata_q    <= chardata_d;
      isstring_q    <= isstring_d;
      ispattern_q   <= ispattern_d;
      res_valid_q   <= res_valid_d;
      res_match_q   <= res_match_d;
      res_index_q   <= res_index_d;
      res_timeout_q <= res_timeout_d;
      err_q         <= err_d;
    end
  end

  assign bus.in_ready    = ready_q;
  assign bus.chardata    = chardata_q;
  assign bus.isstring    = isstring_q;
  assign bus.ispattern   = ispattern_q;
  assign bus.res_valid   = res_valid_q;
  assign bus.res_match   = res_match_q;
  assign bus.res_index   = res_index_q;
  assign bus.res_timeout = res_timeout_q;
  assign bus.err         = err_q;
  assign dbg_state       = state;

endmodule

// File: tb/tb_sme_feeder.sv
// Randomized scoreboard bench for sme_feeder with a record-level reference model.
module tb_sme_feeder;
  import sme_pkg::*;

  localparam int STR_MAX = 32;
  localparam int PAT_MAX = 8;
  localparam int TIMEOUT = 64;

  logic clk;
  logic reset;
  sme_feed_state_t dbg_state;
  sme_feeder_if bus();

  sme_feeder #(.STR_MAX(STR_MAX), .PAT_MAX(PAT_MAX), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int compared   = 0;
  int mismatched = 0;

  logic [10:0] exp_burst_q[$];   // {isstring, ispattern, in_ready, chardata}
  int          exp_len_q[$];
  logic [7:0]  exp_err_q[$];     // byte whose acceptance raises err
  logic [13:0] exp_res_q[$];     // {match, index, timeout, latency from WAIT_RES entry}
  int          plan_d_q[$];      // SME answer delay in cycles after WAIT_RES entry
  logic [5:0]  plan_r_q[$];      // {match, index} the SME answers with
  logic        str_loaded_m = 1'b0;

  int          cyc = 0;
  int          run_len = 0;
  logic        last_pat = 1'b0;
  logic        armed = 1'b0;
  int          wcnt = 0;
  int          wait0 = 0;
  int          cur_d = 0;
  logic [5:0]  cur_r = '0;
  logic        prev_acc = 1'b0;
  logic [7:0]  prev_acc_data = '0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called and returns at posedge+2; accepted at the next posedge when in_ready is high.
  task automatic send_byte(input logic k, input logic [7:0] d, input logic last);
    int budget = 0;
    bus.in_valid = 1'b0;
    repeat ($urandom_range(0, 2)) begin @(posedge clk); #2; end
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_kind  = k;
    bus.in_last  = last;
    while (!bus.in_ready && budget < 500) begin
      @(posedge clk); #2;
      budget++;
    end
    if (budget >= 500) check("in_ready_timeout", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #2;
    bus.in_valid = 1'b0;
  endtask

  // Reference model: what a whole record must produce, derived from the record rules.
  task automatic send_record(input logic k, input logic [7:0] bytes[$], input int d,
                             input logic m, input logic [4:0] idx);
    int lim = k ? PAT_MAX : STR_MAX;
    int n   = bytes.size();
    int emit_n = (n < lim) ? n : lim;
    if (n > lim) exp_err_q.push_back(bytes[lim]);
    if (k && !str_loaded_m) begin
      if (n - 1 != lim) exp_err_q.push_back(bytes[n-1]);
    end else begin
      for (int i = 0; i < emit_n; i++) exp_burst_q.push_back({!k, k, 1'b0, bytes[i]});
      exp_len_q.push_back(emit_n);
      if (!k) str_loaded_m = 1'b1;
      else begin
        plan_d_q.push_back(d);
        plan_r_q.push_back({m, idx});
        if (d < TIMEOUT) exp_res_q.push_back({m, idx, 1'b0, 7'(d + 1)});
        else             exp_res_q.push_back({1'b0, 5'd0, 1'b1, 7'(TIMEOUT)});
      end
    end
    for (int i = 0; i < n; i++) send_byte(k, bytes[i], i == n - 1);
  endtask

  task automatic send_str(input logic k, input string s, input int d,
                          input logic m, input logic [4:0] idx);
    logic [7:0] q[$];
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    send_record(k, q, d, m, idx);
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_burst_q.size() != 0 || exp_len_q.size() != 0 || exp_err_q.size() != 0 ||
            exp_res_q.size() != 0 || armed) && t < 3000) begin
      @(posedge clk); #2;
      t++;
    end
    repeat (4) begin @(posedge clk); #2; end
  endtask

  // ---------------- monitor + SME model ----------------
  initial begin
    bus.sme_valid = 1'b0;
    bus.sme_match = 1'b0;
    bus.sme_index = '0;
    forever begin
      @(negedge clk);
      cyc++;
      // burst characters and burst length (a gap would split a burst)
      if (bus.isstring || bus.ispattern) begin
        if (exp_burst_q.size() == 0)
          check("burst_extra", {21'd0, bus.isstring, bus.ispattern, bus.in_ready, bus.chardata}, 32'd0);
        else
          check("burst_char", {21'd0, bus.isstring, bus.ispattern, bus.in_ready, bus.chardata},
                {21'd0, exp_burst_q.pop_front()});
        run_len++;
        last_pat = bus.ispattern;
      end else if (run_len > 0) begin
        if (exp_len_q.size() == 0) check("burst_len_extra", 32'(run_len), 32'd0);
        else                       check("burst_len", 32'(run_len), 32'(exp_len_q.pop_front()));
        if (last_pat && !reset) begin
          if (plan_d_q.size() == 0) check("sme_plan_missing", 32'(run_len), 32'd0);
          else begin
            cur_d = plan_d_q.pop_front();
            cur_r = plan_r_q.pop_front();
            armed = 1'b1;
            wcnt  = 0;
            wait0 = cyc;
          end
        end
        run_len = 0;
      end
      // result pulse
      if (bus.res_valid) begin
        armed = 1'b0;
        if (exp_res_q.size() == 0)
          check("res_extra", 32'(bus.res_valid), 32'd0);
        else
          check("res_value", {18'd0, bus.res_match, bus.res_index, bus.res_timeout, 7'(cyc - wait0)},
                {18'd0, exp_res_q.pop_front()});
      end
      // error pulse, attributed to the byte accepted at the previous edge
      if (bus.err) begin
        if (exp_err_q.size() == 0) check("err_extra", 32'(bus.err), 32'd0);
        else check("err_byte", {23'd0, prev_acc, prev_acc_data}, {23'd0, 1'b1, exp_err_q.pop_front()});
      end
      prev_acc      = bus.in_valid && bus.in_ready && !reset;
      prev_acc_data = bus.in_data;
      if (reset) begin
        check("reset_outputs", {12'd0, bus.in_ready, bus.isstring, bus.ispattern, bus.chardata,
              bus.res_valid, bus.res_match, bus.res_index, bus.res_timeout, bus.err}, 32'd0);
        prev_acc = 1'b0;
      end
      // SME: answer at the planned WAIT_RES cycle, random noise when no answer is pending
      if (armed) begin
        if (wcnt == cur_d) begin
          bus.sme_valid = 1'b1;
          bus.sme_match = cur_r[5];
          bus.sme_index = cur_r[4:0];
          armed = 1'b0;
        end else begin
          bus.sme_valid = 1'b0;
        end
        wcnt++;
      end else begin
        bus.sme_valid = ($urandom_range(0, 3) == 0);
        bus.sme_match = 1'($urandom_range(0, 1));
        bus.sme_index = 5'($urandom_range(0, 31));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] q[$];
    logic       k;
    int         n;
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_kind  = 1'b0;
    bus.in_last  = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;

    // orphan pattern straight after reset
    send_str(1'b1, "x", 0, 1'b0, 5'd0);
    check("orphan_ready", 32'(bus.in_ready), 32'd1);
    send_str(1'b0, "abcd", 0, 1'b0, 5'd0);
    send_str(1'b1, "bc", 5, 1'b1, 5'd1);
    send_str(1'b1, "abcdefghij", 10, 1'b1, 5'd7);
    send_str(1'b1, "zz", 200, 1'b1, 5'd3);          // silent SME -> timeout
    send_str(1'b1, "q", TIMEOUT - 1, 1'b1, 5'd31);  // SME answers on the timeout cycle
    send_str(1'b1, "r", 0, 1'b0, 5'd9);

    for (int r = 0; r < 14; r++) begin
      k = ($urandom_range(0, 2) != 0);
      n = k ? $urandom_range(1, 12) : $urandom_range(1, 40);
      q.delete();
      for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(33, 126)));
      send_record(k, q, $urandom_range(0, 70), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
    end
    drain();

    // reset during the 2nd cycle of a string burst
    exp_burst_q.push_back({1'b1, 1'b0, 1'b0, 8'h77});
    exp_len_q.push_back(1);
    send_byte(1'b0, 8'h77, 1'b0);
    send_byte(1'b0, 8'h78, 1'b0);
    send_byte(1'b0, 8'h79, 1'b0);
    send_byte(1'b0, 8'h7A, 1'b1);
    @(posedge clk); #2;
    reset = 1'b1;
    repeat (3) begin @(posedge clk); #2; end
    reset = 1'b0;
    str_loaded_m = 1'b0;
    send_str(1'b1, "p", 0, 1'b0, 5'd0);
    drain();

    check("left_burst", 32'(exp_burst_q.size()), 32'd0);
    check("left_len", 32'(exp_len_q.size()), 32'd0);
    check("left_err", 32'(exp_err_q.size()), 32'd0);
    check("left_res", 32'(exp_res_q.size()), 32'd0);
    check("left_plan", 32'(plan_d_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
